// File: rtl/monopix_data_tx.sv
// Chip-side readout transmitter: buffers hit words in a small FIFO, raises
// Token_Out while words are pending and shifts one word MSB-first on Data_Out
// for every rising edge of READ.
module monopix_data_tx #(
    parameter int                    WORD_WIDTH   = 26,
    parameter int                    FIFO_DEPTH   = 8,
    parameter logic [WORD_WIDTH-1:0] TEST_PATTERN = 26'h2AAAAAA
) (
    input  logic                  Clk_Out,
    input  logic                  nRST,
    input  logic                  Hit_Wr,
    input  logic [WORD_WIDTH-1:0] Hit_Data,
    input  logic                  FREEZE,
    input  logic                  READ,
    input  logic                  EN_Test_Pattern,
    output logic                  Token_Out,
    output logic                  Data_Out,
    output logic                  Busy,
    output logic [7:0]            Lost_Cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = $clog2(WORD_WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state, state_next;
    logic                   read_q;
    logic                   rd_edge;
    logic [WORD_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [CNT_W-1:0]       count, count_next;
    logic                   fifo_full, fifo_empty;
    logic                   push, pop, load, lost_inc;
    logic [WORD_WIDTH-1:0]  load_word;
    logic [WORD_WIDTH-1:0]  shreg;
    logic [BIT_W-1:0]       bit_cnt;
    logic                   last_bit;

    assign rd_edge    = READ & ~read_q;
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign last_bit   = (bit_cnt == BIT_W'(WORD_WIDTH - 1));
    assign Busy       = (state == SHIFT);

    // State register.
    // NOTE: sequential state always uses non-blocking (<=) assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clk_Out or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic, FIFO push/pop decisions and the word to load.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        pop        = 1'b0;
        load_word  = TEST_PATTERN;
        case (state)
            IDLE: begin
                if (rd_edge) begin
                    if (EN_Test_Pattern) begin
                        load       = 1'b1;
                        state_next = SHIFT;
                    end else if (!fifo_empty) begin
                        load       = 1'b1;
                        pop        = 1'b1;
                        load_word  = mem[rd_ptr];
                        state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (last_bit) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        push     = Hit_Wr & ~FREEZE & (~fifo_full | pop);
        lost_inc = Hit_Wr & ~FREEZE & fifo_full & ~pop;

        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // FIFO storage.
    // NOTE: the word array carries no reset; validity is tracked by the
    // pointers and count, so clearing it would only add reset fan-out.
    always_ff @(posedge Clk_Out) begin
        if (push) mem[wr_ptr] <= Hit_Data;
    end

    // FIFO pointers, occupancy count, READ history and lost-hit counter.
    always_ff @(posedge Clk_Out or negedge nRST) begin
        if (!nRST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            read_q   <= 1'b0;
            Lost_Cnt <= '0;
        end else begin
            read_q <= READ;
            count  <= count_next;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (lost_inc && Lost_Cnt != 8'hFF) Lost_Cnt <= Lost_Cnt + 8'd1;
        end
    end

    // Serializer: the MSB goes out the cycle after the load, then one bit per
    // cycle; Data_Out returns to 0 once the last bit has been shown.
    always_ff @(posedge Clk_Out or negedge nRST) begin
        if (!nRST) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            Data_Out <= 1'b0;
        end else if (load) begin
            shreg    <= load_word << 1;
            bit_cnt  <= '0;
            Data_Out <= load_word[WORD_WIDTH-1];
        end else if (state == SHIFT) begin
            if (last_bit) begin
                Data_Out <= 1'b0;
            end else begin
                Data_Out <= shreg[WORD_WIDTH-1];
                shreg    <= shreg << 1;
                bit_cnt  <= bit_cnt + BIT_W'(1);
            end
        end
    end

    // Token stays up while anything is queued or a word is (still) shifting.
    always_ff @(posedge Clk_Out or negedge nRST) begin
        if (!nRST) Token_Out <= 1'b0;
        else       Token_Out <= (count_next != '0) || (state_next == SHIFT);
    end

endmodule

// File: tb/tb_monopix_data_tx.sv
// Directed bench for monopix_data_tx: FIFO ordering, READ edge detection,
// overflow accounting, FREEZE, test pattern and asynchronous reset.
module tb_monopix_data_tx;

    localparam int WW = 26;

    logic          Clk_Out;
    logic          nRST;
    logic          Hit_Wr;
    logic [WW-1:0] Hit_Data;
    logic          FREEZE;
    logic          READ;
    logic          EN_Test_Pattern;
    logic          Token_Out;
    logic          Data_Out;
    logic          Busy;
    logic [7:0]    Lost_Cnt;

    int n_cmp = 0;
    int n_err = 0;

    monopix_data_tx dut (
        .Clk_Out         (Clk_Out),
        .nRST            (nRST),
        .Hit_Wr          (Hit_Wr),
        .Hit_Data        (Hit_Data),
        .FREEZE          (FREEZE),
        .READ            (READ),
        .EN_Test_Pattern (EN_Test_Pattern),
        .Token_Out       (Token_Out),
        .Data_Out        (Data_Out),
        .Busy            (Busy),
        .Lost_Cnt        (Lost_Cnt)
    );

    initial Clk_Out = 1'b0;
    always #5 Clk_Out = ~Clk_Out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge Clk_Out);
        #1;
    endtask

    task automatic do_reset();
        nRST            = 1'b0;
        Hit_Wr          = 1'b0;
        Hit_Data        = '0;
        FREEZE          = 1'b0;
        READ            = 1'b0;
        EN_Test_Pattern = 1'b0;
        step();
        step();
        nRST = 1'b1;
        step();
    endtask

    task automatic write_word(input logic [WW-1:0] w);
        Hit_Wr   = 1'b1;
        Hit_Data = w;
        step();
        Hit_Wr   = 1'b0;
    endtask

    // READ must already be high (with READ low at the previous edge); the next
    // edge is the request edge. Checks every serial bit, then the idle return.
    task automatic shift_check(input logic [WW-1:0] w, input string tag);
        for (int i = WW - 1; i >= 0; i--) begin
            step();
            check($sformatf("%s_bit%0d", tag, i), 32'(Data_Out), 32'(w[i]));
            if (i == WW - 1) begin
                check({tag, "_busy"}, 32'(Busy), 32'd1);
                check({tag, "_tok"}, 32'(Token_Out), 32'd1);
            end
        end
        step();
        check({tag, "_idle_data"}, 32'(Data_Out), 32'd0);
        check({tag, "_idle_busy"}, 32'(Busy), 32'd0);
    endtask

    function automatic logic [WW-1:0] fill_word(input int i);
        logic [WW-1:0] base;
        logic [WW-1:0] inc;
        base = 26'h1000001;
        inc  = 26'h0111111;
        return base + inc * WW'(i);
    endfunction

    initial begin
        logic [WW-1:0] w;
        logic [WW-1:0] a, b, c, extra;
        a     = 26'h3FF0001;
        b     = 26'h155AA33;
        c     = 26'h0C3C3C3;
        extra = 26'h2BEEF00;

        // 1: reset values, single word round trip
        do_reset();
        check("rst_token", 32'(Token_Out), 32'd0);
        check("rst_data", 32'(Data_Out), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_lost", 32'(Lost_Cnt), 32'd0);
        w = 26'h1234567;
        write_word(w);
        check("t1_token_after_wr", 32'(Token_Out), 32'd1);
        READ = 1'b1;
        shift_check(w, "t1");
        READ = 1'b0;
        check("t1_token_fall", 32'(Token_Out), 32'd0);

        // 2: level-held READ sends one word only; ordering A,B,C
        step();
        write_word(a);
        write_word(b);
        write_word(c);
        READ = 1'b1;
        shift_check(a, "t2a");
        repeat (73) step();
        check("t2_held_busy", 32'(Busy), 32'd0);
        check("t2_held_data", 32'(Data_Out), 32'd0);
        check("t2_held_token", 32'(Token_Out), 32'd1);
        READ = 1'b0;
        step();
        READ = 1'b1;
        shift_check(b, "t2b");
        check("t2_token_after_b", 32'(Token_Out), 32'd1);
        READ = 1'b0;
        step();
        READ = 1'b1;
        shift_check(c, "t2c");
        check("t2_token_after_c", 32'(Token_Out), 32'd0);
        READ = 1'b0;

        // 3: overflow, same-cycle pop on full FIFO, saturation
        do_reset();
        Hit_Wr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            Hit_Data = fill_word(i);
            step();
        end
        check("t3_full_lost", 32'(Lost_Cnt), 32'd0);
        Hit_Data = 26'h3333333;
        repeat (3) step();
        Hit_Wr = 1'b0;
        check("t3_lost3", 32'(Lost_Cnt), 32'd3);
        READ     = 1'b1;
        Hit_Wr   = 1'b1;
        Hit_Data = extra;
        step();
        Hit_Wr = 1'b0;
        READ   = 1'b0;
        check("t3_popwr_lost", 32'(Lost_Cnt), 32'd3);
        check("t3_popwr_busy", 32'(Busy), 32'd1);
        w = fill_word(0);
        check("t3_w0_bit25", 32'(Data_Out), 32'(w[WW-1]));
        for (int i = WW - 2; i >= 0; i--) begin
            step();
            check($sformatf("t3_w0_bit%0d", i), 32'(Data_Out), 32'(w[i]));
        end
        step();
        Hit_Wr = 1'b1;
        repeat (260) step();
        Hit_Wr = 1'b0;
        check("t3_lost_sat", 32'(Lost_Cnt), 32'd255);
        for (int k = 1; k < 8; k++) begin
            READ = 1'b1;
            shift_check(fill_word(k), $sformatf("t3_w%0d", k));
            READ = 1'b0;
            step();
        end
        READ = 1'b1;
        shift_check(extra, "t3_extra");
        READ = 1'b0;
        check("t3_drained_token", 32'(Token_Out), 32'd0);

        // 4: FREEZE drops silently
        do_reset();
        FREEZE = 1'b1;
        for (int i = 0; i < 5; i++) begin
            write_word(26'h0000F0F + WW'(i));
            step();
        end
        FREEZE = 1'b0;
        check("t4_token", 32'(Token_Out), 32'd0);
        check("t4_lost", 32'(Lost_Cnt), 32'd0);
        READ = 1'b1;
        step();
        step();
        READ = 1'b0;
        check("t4_busy", 32'(Busy), 32'd0);
        check("t4_data", 32'(Data_Out), 32'd0);

        // 5: test pattern does not pop the FIFO
        do_reset();
        w = 26'h0F0F0F0;
        write_word(w);
        EN_Test_Pattern = 1'b1;
        READ = 1'b1;
        shift_check(26'h2AAAAAA, "t5_tp");
        READ = 1'b0;
        EN_Test_Pattern = 1'b0;
        check("t5_token_kept", 32'(Token_Out), 32'd1);
        step();
        READ = 1'b1;
        shift_check(w, "t5_word");
        READ = 1'b0;
        check("t5_token_fall", 32'(Token_Out), 32'd0);

        // 6: asynchronous reset mid-shift
        do_reset();
        w = 26'h1234567;
        write_word(w);
        READ = 1'b1;
        step();
        READ = 1'b0;
        repeat (15) step();
        check("t6_bit10", 32'(Data_Out), 32'(w[10]));
        nRST = 1'b0;
        #1;
        check("t6_rst_data", 32'(Data_Out), 32'd0);
        check("t6_rst_busy", 32'(Busy), 32'd0);
        check("t6_rst_token", 32'(Token_Out), 32'd0);
        check("t6_rst_lost", 32'(Lost_Cnt), 32'd0);
        #3;
        nRST = 1'b1;
        step();
        READ = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t6_after_busy%0d", i), 32'(Busy), 32'd0);
            check($sformatf("t6_after_data%0d", i), 32'(Data_Out), 32'd0);
        end
        READ = 1'b0;
        check("t6_after_token", 32'(Token_Out), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
